// File: rtl/rs_ls_age_queue.sv
// rs_ls_age_queue: age-ordered load/store reservation station with a registered issue stage.
// Define RS_LS_MEM_ORDER_EN to keep loads from passing older stores.
module rs_ls_age_queue #(
    parameter int DEPTH  = 32,
    parameter int TAG_W  = 8,
    parameter int NUM_WB = 7,
    parameter int INST_W = 32,
    parameter int IMM_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [INST_W-1:0]          disp_inst_num,
    input  logic [TAG_W-1:0]           disp_rd,
    input  logic [8:0]                 disp_ctrl,
    input  logic [2:0]                 disp_funct3,
    input  logic [IMM_W-1:0]           disp_imm,
    input  logic [TAG_W-1:0]           disp_src1,
    input  logic [TAG_W-1:0]           disp_src2,
    input  logic [1:0]                 disp_src_rdy,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [INST_W-1:0]          iss_inst_num,
    output logic [TAG_W-1:0]           iss_rd,
    output logic [8:0]                 iss_ctrl,
    output logic [2:0]                 iss_funct3,
    output logic [IMM_W-1:0]           iss_imm,
    output logic [TAG_W-1:0]           iss_src1,
    output logic [TAG_W-1:0]           iss_src2,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_n;

    logic [DEPTH-1:0]  vld, r1, r2, w1, w2, cand, sel;
    logic [DEPTH-1:0]  older [DEPTH];
    logic [INST_W-1:0] e_inst [DEPTH];
    logic [TAG_W-1:0]  e_rd [DEPTH];
    logic [8:0]        e_ctrl [DEPTH];
    logic [2:0]        e_funct3 [DEPTH];
    logic [IMM_W-1:0]  e_imm [DEPTH];
    logic [TAG_W-1:0]  e_src1 [DEPTH];
    logic [TAG_W-1:0]  e_src2 [DEPTH];
    logic [IW-1:0]     sel_idx, alloc_idx;
    logic              b1, b2, any, load, issue, alloc;

    assign disp_ready = occupancy < OW'(DEPTH);
    assign alloc      = disp_valid & disp_ready;
    assign iss_valid  = state == FULL;
    assign load       = ~iss_valid | iss_ready;
    assign any        = |cand;
    assign issue      = load & any;

    always_comb begin
        w1 = '0;
        w2 = '0;
        b1 = 1'b0;
        b2 = 1'b0;
        for (int c = 0; c < NUM_WB; c++) begin
            if (wb_valid[c] && wb_tag[c*TAG_W +: TAG_W] == disp_src1) b1 = 1'b1;
            if (wb_valid[c] && wb_tag[c*TAG_W +: TAG_W] == disp_src2) b2 = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_valid[c] && wb_tag[c*TAG_W +: TAG_W] == e_src1[i]) w1[i] = 1'b1;
                if (wb_valid[c] && wb_tag[c*TAG_W +: TAG_W] == e_src2[i]) w2[i] = 1'b1;
            end
        end
    end

`ifdef RS_LS_MEM_ORDER_EN
    logic [DEPTH-1:0] st;
    logic             st_hold;
    assign st_hold = iss_valid & ~iss_ready & iss_ctrl[6];
    always_comb begin
        st = '0;
        for (int i = 0; i < DEPTH; i++) st[i] = e_ctrl[i][6];
    end
`endif

    // older[i][j] set means entry j was allocated before entry i
    always_comb begin
        cand    = vld & r1 & r2;
`ifdef RS_LS_MEM_ORDER_EN
        for (int i = 0; i < DEPTH; i++)
            if (e_ctrl[i][7] && ((|(older[i] & vld & st)) || st_hold)) cand[i] = 1'b0;
`endif
        sel     = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = cand[i] & ~|(cand & older[i]);
            if (sel[i]) sel_idx = IW'(i);
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!vld[i]) alloc_idx = IW'(i);
    end

    always_comb state_n = flush ? EMPTY : load ? (any ? FULL : EMPTY) : state;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= EMPTY;
        else state <= state_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || flush) begin
            vld       <= '0;
            r1        <= '0;
            r2        <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            r1 <= r1 | w1;
            r2 <= r2 | w2;
            if (issue) vld[sel_idx] <= 1'b0;
            if (alloc) begin
                vld[alloc_idx]   <= 1'b1;
                r1[alloc_idx]    <= disp_src_rdy[0] | b1;
                r2[alloc_idx]    <= disp_src_rdy[1] | b2;
                older[alloc_idx] <= vld;
                for (int i = 0; i < DEPTH; i++) older[i][alloc_idx] <= 1'b0;
            end
            occupancy <= occupancy + OW'(alloc) - OW'(issue);
        end
    end

    always_ff @(posedge clk)
        if (alloc) begin
            e_inst[alloc_idx]   <= disp_inst_num;
            e_rd[alloc_idx]     <= disp_rd;
            e_ctrl[alloc_idx]   <= disp_ctrl;
            e_funct3[alloc_idx] <= disp_funct3;
            e_imm[alloc_idx]    <= disp_imm;
            e_src1[alloc_idx]   <= disp_src1;
            e_src2[alloc_idx]   <= disp_src2;
        end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || flush) begin
            iss_inst_num <= '0;
            iss_rd       <= '0;
            iss_ctrl     <= '0;
            iss_funct3   <= '0;
            iss_imm      <= '0;
            iss_src1     <= '0;
            iss_src2     <= '0;
        end else if (issue) begin
            iss_inst_num <= e_inst[sel_idx];
            iss_rd       <= e_rd[sel_idx];
            iss_ctrl     <= e_ctrl[sel_idx];
            iss_funct3   <= e_funct3[sel_idx];
            iss_imm      <= e_imm[sel_idx];
            iss_src1     <= e_src1[sel_idx];
            iss_src2     <= e_src2[sel_idx];
        end
    end
endmodule

// File: tb/tb_rs_ls_age_queue.sv
// tb_rs_ls_age_queue: scenario tasks drive the station; a monitor pops the expected issue order.
module tb_rs_ls_age_queue;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [31:0] disp_inst_num = '0;
    logic [7:0]  disp_rd = '0;
    logic [8:0]  disp_ctrl = '0;
    logic [2:0]  disp_funct3 = '0;
    logic [31:0] disp_imm = '0;
    logic [7:0]  disp_src1 = '0;
    logic [7:0]  disp_src2 = '0;
    logic [1:0]  disp_src_rdy = '0;
    logic [6:0]  wb_valid = '0;
    logic [55:0] wb_tag = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b1;
    logic [31:0] iss_inst_num;
    logic [7:0]  iss_rd;
    logic [8:0]  iss_ctrl;
    logic [2:0]  iss_funct3;
    logic [31:0] iss_imm;
    logic [7:0]  iss_src1;
    logic [7:0]  iss_src2;
    logic [5:0]  occupancy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic        accepted;

    rs_ls_age_queue dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst_num(disp_inst_num),
        .disp_rd(disp_rd), .disp_ctrl(disp_ctrl), .disp_funct3(disp_funct3), .disp_imm(disp_imm),
        .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_src_rdy(disp_src_rdy),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst_num(iss_inst_num),
        .iss_rd(iss_rd), .iss_ctrl(iss_ctrl), .iss_funct3(iss_funct3), .iss_imm(iss_imm),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // every accepted issue must be the next expected op, with fields derived from its number
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset_n && iss_valid && iss_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL issue_unexpected: got inst %0d, required none", iss_inst_num);
            end else begin
                e = exp_q.pop_front();
                if (iss_inst_num !== e || iss_rd !== (e[7:0] ^ 8'hA5) || iss_imm !== (e ^ 32'h5A5A0000)) begin
                    miscompares++;
                    $display("FAIL issue_order: got inst %0d rd %h imm %h, required inst %0d rd %h imm %h",
                             iss_inst_num, iss_rd, iss_imm, e, e[7:0] ^ 8'hA5, e ^ 32'h5A5A0000);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [31:0] inst, input logic [7:0] s1, input logic [7:0] s2,
                            input logic [1:0] rdy, input logic [8:0] ctrl);
        disp_inst_num = inst;
        disp_rd       = inst[7:0] ^ 8'hA5;
        disp_imm      = inst ^ 32'h5A5A0000;
        disp_funct3   = inst[2:0];
        disp_src1     = s1;
        disp_src2     = s2;
        disp_src_rdy  = rdy;
        disp_ctrl     = ctrl;
        disp_valid    = 1'b1;
        accepted      = disp_ready;
        tick();
        disp_valid    = 1'b0;
    endtask

    task automatic wake(input int ch, input logic [7:0] tag);
        wb_valid = '0;
        wb_valid[ch] = 1'b1;
        wb_tag[ch*8 +: 8] = tag;
        tick();
        wb_valid = '0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d ops never issued, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
        vectors++;
        if (iss_valid !== 1'b0 || occupancy !== 6'd0) begin
            miscompares++;
            $display("FAIL %s_idle: iss_valid %b occupancy %0d, required 0 0", name, iss_valid, occupancy);
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (iss_valid !== 1'b0 || occupancy !== 6'd0 || disp_ready !== 1'b1 || iss_inst_num !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: iss_valid %b occ %0d disp_ready %b inst %0d, required 0 0 1 0",
                     iss_valid, occupancy, disp_ready, iss_inst_num);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_wakeup_order();
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd1);
        dispatch(32'd1, 8'h11, 8'h12, 2'b10, 9'h000);
        dispatch(32'd2, 8'h13, 8'h14, 2'b11, 9'h000);
        wake(0, 8'h11);
        wait_drain("wakeup_order");
    endtask

    task automatic test_bypass();
        exp_q.push_back(32'd300);
        wb_valid = 7'b0001000;
        wb_tag[24 +: 8] = 8'h20;
        dispatch(32'd300, 8'h20, 8'h21, 2'b10, 9'h000);
        wb_valid = '0;
        check("bypass_e0_valid", {31'd0, iss_valid}, 32'd0);
        tick();
        check("bypass_e1_valid", {31'd0, iss_valid}, 32'd1);
        check("bypass_e1_inst", iss_inst_num, 32'd300);
        wait_drain("bypass");
    endtask

    task automatic test_tag_zero();
        exp_q.push_back(32'd350);
        dispatch(32'd350, 8'h77, 8'h00, 2'b01, 9'h000);
        tick();
        check("tag0_waiting", {26'd0, occupancy}, 32'd1);
        wake(6, 8'h00);
        wait_drain("tag_zero");
    endtask

    task automatic test_backpressure();
        iss_ready = 1'b0;
        exp_q.push_back(32'd401);
        exp_q.push_back(32'd400);
        dispatch(32'd400, 8'h33, 8'h34, 2'b10, 9'h000);
        dispatch(32'd401, 8'h35, 8'h36, 2'b11, 9'h000);
        tick();
        wake(1, 8'h33);
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_valid", {31'd0, iss_valid}, 32'd1);
            check("bp_hold_inst", iss_inst_num, 32'd401);
            check("bp_hold_occ", {26'd0, occupancy}, 32'd1);
            tick();
        end
        iss_ready = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'd500 + 32'(i));
            dispatch(32'd500 + 32'(i), 8'h40, 8'h41, 2'b11, 9'h000);
            check("b2b_occ", {26'd0, occupancy}, 32'd1);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_full_and_flush();
        for (int i = 0; i < 32; i++) dispatch(32'd100 + 32'(i), 8'h80 + 8'(i), 8'h00, 2'b10, 9'h000);
        check("full_occ", {26'd0, occupancy}, 32'd32);
        check("full_disp_ready", {31'd0, disp_ready}, 32'd0);
        dispatch(32'd200, 8'h00, 8'h00, 2'b11, 9'h000);
        check("full_33rd_accepted", {31'd0, accepted}, 32'd0);
        check("full_33rd_occ", {26'd0, occupancy}, 32'd32);
        exp_q.push_back(32'd105);
        wake(2, 8'h85);
        tick();
        check("full_free_ready", {31'd0, disp_ready}, 32'd1);
        check("full_free_occ", {26'd0, occupancy}, 32'd31);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("full_issued", 32'(exp_q.size()), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_occ", {26'd0, occupancy}, 32'd0);
        check("flush_ready", {31'd0, disp_ready}, 32'd1);
        check("flush_iss_inst", iss_inst_num, 32'd0);
        wake(0, 8'h90);
        tick();
        check("flush_no_ghost", {31'd0, iss_valid}, 32'd0);
    endtask

    task automatic test_mem_order();
`ifdef RS_LS_MEM_ORDER_EN
        exp_q.push_back(32'd600);
        exp_q.push_back(32'd601);
`else
        exp_q.push_back(32'd601);
        exp_q.push_back(32'd600);
`endif
        dispatch(32'd600, 8'h05, 8'h06, 2'b10, 9'h040);
        dispatch(32'd601, 8'h07, 8'h08, 2'b11, 9'h080);
        wake(3, 8'h05);
        wait_drain("mem_order");
    endtask

    task automatic test_reset_midstream();
        iss_ready = 1'b0;
        dispatch(32'd700, 8'h50, 8'h51, 2'b11, 9'h000);
        for (int i = 0; i < 5; i++) dispatch(32'd701 + 32'(i), 8'hC0 + 8'(i), 8'h00, 2'b10, 9'h000);
        tick();
        check("mid_pre_occ", {26'd0, occupancy}, 32'd5);
        check("mid_pre_valid", {31'd0, iss_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_reset_valid", {31'd0, iss_valid}, 32'd0);
        check("mid_reset_occ", {26'd0, occupancy}, 32'd0);
        check("mid_reset_ready", {31'd0, disp_ready}, 32'd1);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        iss_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_wakeup_order();
        test_bypass();
        test_tag_zero();
        test_backpressure();
        test_back_to_back();
        test_full_and_flush();
        test_mem_order();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
